bp_lite_to_stream_buffered: RTL and testbench

- Successor lite-to-stream converter for BedRock memory messages.
- Accepts full lite messages (header plus in_data_width_p data) into a multi-entry buffer, so several messages can be outstanding, not one.
- Serialises each buffered message into out_data_width_p stream beats in critical-word-first order. The beat address wraps within the size-aligned window.
- Sits between lite masters (e.g. cache/IO engines) and stream clients (e.g. wormhole/DRAM adapters) in bp_me.

---
 rtl/bp_lite_to_stream_buffered.sv | 144 ++++++++++++++
 tb/tb_bp_lite_to_stream_buffered.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_lite_to_stream_buffered.sv
// Buffered lite-to-stream converter for BedRock-style memory messages.
//
// Whole lite messages ({header, data}) are queued in a buffer_els_p-entry
// FIFO. The head message is serialised into out_data_width_p beats in
// critical-word-first order, the beat address wrapping inside the
// size-aligned window of N beats.
//
// Header layout (LSB first):
//   [3:0]                    msg_type
//   [4 +: paddr_width_p]     addr
//   [4+paddr_width_p +: 3]   size (2^size bytes)
//   above that               lce_id, way_id (passed through)
//
// Ports:
//   clk_i         clock
//   reset_i       synchronous active-high reset
//   mem_i         lite message {header, data}
//   mem_v_i       lite valid
//   mem_ready_o   buffer can accept a message
//   mem_header_o  header with per-beat address
//   mem_data_o    beat data
//   mem_v_o       beat valid
//   mem_ready_i   stream client ready
//   mem_last_o    final beat of the current message
module bp_lite_to_stream_buffered #(
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned lce_id_width_p   = 4,
  parameter int unsigned lce_assoc_p      = 8,
  parameter int unsigned in_data_width_p  = 512,
  parameter int unsigned out_data_width_p = 64,
  parameter logic [15:0] payload_mask_p   = '0,
  parameter int unsigned buffer_els_p     = 2,
  localparam int unsigned way_w_lp        = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int unsigned hdr_w_lp        = 4 + paddr_width_p + 3 + lce_id_width_p + way_w_lp,
  localparam int unsigned in_mem_msg_width_lp = hdr_w_lp + in_data_width_p,
  localparam int unsigned out_mem_msg_header_width_lp = hdr_w_lp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [in_mem_msg_width_lp-1:0]         mem_i,
  input  logic                                   mem_v_i,
  output logic                                   mem_ready_o,
  output logic [out_mem_msg_header_width_lp-1:0] mem_header_o,
  output logic [out_data_width_p-1:0]            mem_data_o,
  output logic                                   mem_v_o,
  input  logic                                   mem_ready_i,
  output logic                                   mem_last_o
);

  localparam int unsigned W        = in_data_width_p / out_data_width_p;
  localparam int unsigned off_w    = $clog2(out_data_width_p / 8);
  localparam int unsigned lg_w     = $clog2(W);
  localparam int unsigned idx_w    = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned ptr_w    = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;
  localparam int unsigned addr_lsb = 4;
  localparam int unsigned size_lsb = 4 + paddr_width_p;

  logic [in_mem_msg_width_lp-1:0] buf_q [buffer_els_p];
  logic [ptr_w-1:0]               wr_ptr_q, rd_ptr_q;
  logic [ptr_w:0]                 count_q;
  logic [idx_w-1:0]               cnt_q;

  logic                           full, empty, enq, deq, xfer;
  logic [in_mem_msg_width_lp-1:0] head_msg;
  logic [hdr_w_lp-1:0]            head_hdr;
  logic [in_data_width_p-1:0]     head_data;
  logic [3:0]                     head_type;
  logic [2:0]                     head_size;
  logic [idx_w-1:0]               first, beat_mask, idx_k, sel;
  int unsigned                    lg_n;

  assign full  = (count_q == (ptr_w+1)'(buffer_els_p));
  assign empty = (count_q == '0);

  // Outputs are forced low while reset is held, even if the FIFO still
  // holds a partial burst from before reset.
  assign mem_ready_o = !reset_i && !full;
  assign mem_v_o     = !reset_i && !empty;

  assign enq  = mem_v_i && mem_ready_o;
  assign xfer = mem_v_o && mem_ready_i;
  assign deq  = xfer && mem_last_o;

  assign head_msg  = buf_q[rd_ptr_q];
  assign head_hdr  = head_msg[in_mem_msg_width_lp-1 -: hdr_w_lp];
  assign head_data = head_msg[in_data_width_p-1:0];
  assign head_type = head_hdr[3:0];
  assign head_size = head_hdr[size_lsb +: 3];
  assign first     = head_hdr[addr_lsb+off_w +: idx_w];

  // log2 of the beat count: size beyond one beat, clamped to the block,
  // and a single beat for messages without payload.
  always_comb begin
    lg_n = 0;
    if (32'(head_size) > off_w) lg_n = 32'(head_size) - off_w;
    if (lg_n > lg_w) lg_n = lg_w;
    if (!payload_mask_p[head_type]) lg_n = 0;
    beat_mask = idx_w'((32'd1 << lg_n) - 32'd1);
  end

  assign idx_k      = (first & ~beat_mask) | ((first + cnt_q) & beat_mask);
  assign sel        = idx_k & beat_mask;
  assign mem_last_o = mem_v_o && (cnt_q == beat_mask);

  always_comb begin
    mem_header_o = head_hdr;
    mem_header_o[addr_lsb+off_w +: idx_w] = idx_k;
  end

  assign mem_data_o = head_data[32'(sel)*out_data_width_p +: out_data_width_p];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (enq) wr_ptr_q <= (wr_ptr_q == ptr_w'(buffer_els_p-1)) ? '0 : wr_ptr_q + ptr_w'(1);
      if (deq) rd_ptr_q <= (rd_ptr_q == ptr_w'(buffer_els_p-1)) ? '0 : rd_ptr_q + ptr_w'(1);
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + (ptr_w+1)'(1);
        2'b01:   count_q <= count_q - (ptr_w+1)'(1);
        default: count_q <= count_q;
      endcase
      if (xfer) cnt_q <= mem_last_o ? '0 : cnt_q + idx_w'(1);
    end
  end

  // Payload storage needs no reset: entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (enq) buf_q[wr_ptr_q] <= mem_i;
  end

`ifndef SYNTHESIS
  if (in_data_width_p % out_data_width_p != 0) begin : g_width_chk
    $error("in_data_width_p must be a multiple of out_data_width_p");
  end

  a_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_v_o && !mem_ready_i) |=> ($stable(mem_header_o) && $stable(mem_data_o)));
`endif

endmodule

// File: tb/tb_bp_lite_to_stream_buffered.sv
module tb_bp_lite_to_stream_buffered;

  localparam int HW = 54;
  localparam int DW = 512;
  localparam int MW = HW + DW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [MW-1:0] mem_i;
  logic          mem_v_i;
  logic          mem_ready_o;
  logic [HW-1:0] mem_header_o;
  logic [63:0]   mem_data_o;
  logic          mem_v_o;
  logic          mem_ready_i;
  logic          mem_last_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_lite_to_stream_buffered #(
    .paddr_width_p(40),
    .lce_id_width_p(4),
    .lce_assoc_p(8),
    .in_data_width_p(512),
    .out_data_width_p(64),
    .payload_mask_p(16'h0002),
    .buffer_els_p(2)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .mem_i(mem_i),
    .mem_v_i(mem_v_i),
    .mem_ready_o(mem_ready_o),
    .mem_header_o(mem_header_o),
    .mem_data_o(mem_data_o),
    .mem_v_o(mem_v_o),
    .mem_ready_i(mem_ready_i),
    .mem_last_o(mem_last_o)
  );

  // msg_type 1 = write (payload), 0 = read; lce_id=5, way=3
  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [39:0] a, input logic [2:0] sz);
    mk_hdr = {3'd3, 4'd5, sz, a, t};
  endfunction

  function automatic logic [63:0] beat(input logic [31:0] seed, input int k);
    beat = {seed, 32'(k)};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [31:0] seed);
    for (int k = 0; k < 8; k++) mk_data[k*64 +: 64] = beat(seed, k);
  endfunction

  task automatic send(input logic [MW-1:0] m);
    bit ok;
    ok = 1'b0;
    mem_i = m;
    mem_v_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (mem_ready_o) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    mem_v_i = 1'b0;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL send_accept: accepted=0 required 1 within 50 cycles"); end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; mem_v_i = 1'b0; mem_ready_i = 1'b0; mem_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", mem_ready_o); end
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL reset_v: got %b want 0", mem_v_o); end
    n_cmp++; if (mem_last_o !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", mem_last_o); end
    reset_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", mem_ready_o); end
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL post_reset_v: got %b want 0", mem_v_o); end
  endtask

  // Send one message with ready_i=1 and check its n beats; first = start beat index.
  task automatic run_burst(input string nm, input logic [3:0] t, input logic [39:0] base,
                           input int first, input logic [2:0] sz, input int n, input logic [31:0] seed);
    logic [39:0] a;
    int idx;
    mem_ready_i = 1'b1;
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL %s_idle_v: got %b want 0", nm, mem_v_o); end
    send({mk_hdr(t, base + 40'(first*8), sz), mk_data(seed)});
    for (int k = 0; k < n; k++) begin
      idx = ((first & ~(n-1)) | ((first + k) & (n-1)));
      a = base + 40'(idx*8);
      n_cmp++; if (mem_v_o !== 1'b1) begin n_err++; $display("FAIL %s_v[%0d]: got %b want 1", nm, k, mem_v_o); end
      n_cmp++; if (mem_header_o !== mk_hdr(t, a, sz)) begin n_err++; $display("FAIL %s_hdr[%0d]: got %h want %h", nm, k, mem_header_o, mk_hdr(t, a, sz)); end
      n_cmp++; if (mem_data_o !== beat(seed, idx & (n-1))) begin n_err++; $display("FAIL %s_data[%0d]: got %h want %h", nm, k, mem_data_o, beat(seed, idx & (n-1))); end
      n_cmp++; if (mem_last_o !== (k == n-1)) begin n_err++; $display("FAIL %s_last[%0d]: got %b want %b", nm, k, mem_last_o, (k == n-1)); end
      @(negedge clk);
    end
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL %s_done_v: got %b want 0", nm, mem_v_o); end
  endtask

  task automatic test_aligned_write();  run_burst("aligned", 4'd1, 40'h1000, 0, 3'd6, 8, 32'hA11A0000); endtask
  task automatic test_wrap_write();     run_burst("wrap",    4'd1, 40'h1000, 2, 3'd6, 8, 32'hB22B0000); endtask
  task automatic test_small_write();    run_burst("small",   4'd1, 40'h1010, 1, 3'd4, 2, 32'hC33C0000); endtask
  task automatic test_read();           run_burst("read",    4'd0, 40'h2000, 0, 3'd6, 1, 32'hD44D0000); endtask

  task automatic test_back_to_back();
    logic [39:0] bases [3];
    int          firsts [3];
    logic [31:0] seeds [3];
    logic [39:0] a;
    int m, k, idx;
    bases = '{40'h1000, 40'h1000, 40'h4000};
    firsts = '{0, 2, 7};
    seeds = '{32'h11110000, 32'h22220000, 32'h33330000};
    mem_ready_i = 1'b0;
    mem_v_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_i = {mk_hdr(4'd1, bases[i] + 40'(firsts[i]*8), 3'd6), mk_data(seeds[i])};
      n_cmp++; if (mem_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_accept[%0d]: got %b want 1", i, mem_ready_o); end
      @(negedge clk);
    end
    mem_i = {mk_hdr(4'd1, bases[2] + 40'(firsts[2]*8), 3'd6), mk_data(seeds[2])};
    n_cmp++; if (mem_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b want 0", mem_ready_o); end
    mem_ready_i = 1'b1;
    for (int g = 0; g < 24; g++) begin
      m = g / 8; k = g % 8;
      if (g == 9) mem_v_i = 1'b0;
      if (g <= 8) begin
        n_cmp++; if (mem_ready_o !== (g == 8)) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want %b", g, mem_ready_o, (g == 8)); end
      end
      idx = (firsts[m] + k) % 8;
      a = bases[m] + 40'(idx*8);
      n_cmp++; if (mem_v_o !== 1'b1) begin n_err++; $display("FAIL b2b_v[%0d]: got %b want 1", g, mem_v_o); end
      n_cmp++; if (mem_header_o !== mk_hdr(4'd1, a, 3'd6)) begin n_err++; $display("FAIL b2b_hdr[%0d]: got %h want %h", g, mem_header_o, mk_hdr(4'd1, a, 3'd6)); end
      n_cmp++; if (mem_data_o !== beat(seeds[m], idx)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", g, mem_data_o, beat(seeds[m], idx)); end
      n_cmp++; if (mem_last_o !== (k == 7)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", g, mem_last_o, (k == 7)); end
      @(negedge clk);
    end
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL b2b_done_v: got %b want 0", mem_v_o); end
  endtask

  task automatic test_random_stall();
    logic [HW-1:0] prev_h;
    logic [63:0]   prev_d;
    logic          stalled;
    logic [39:0]   a;
    int xfers, lasts, idx;
    mem_ready_i = 1'b0;
    send({mk_hdr(4'd1, 40'h1020, 3'd6), mk_data(32'h5EED0000)});
    stalled = 1'b0; xfers = 0; lasts = 0;
    for (int c = 0; c < 200 && xfers < 8; c++) begin
      if (stalled) begin
        n_cmp++; if (mem_header_o !== prev_h) begin n_err++; $display("FAIL stall_hdr[%0d]: got %h want %h", c, mem_header_o, prev_h); end
        n_cmp++; if (mem_data_o !== prev_d) begin n_err++; $display("FAIL stall_data[%0d]: got %h want %h", c, mem_data_o, prev_d); end
      end
      mem_ready_i = 1'($urandom_range(0, 1));
      if (mem_v_o && mem_ready_i) begin
        idx = (4 + xfers) % 8;
        a = 40'h1000 + 40'(idx*8);
        n_cmp++; if (mem_header_o !== mk_hdr(4'd1, a, 3'd6)) begin n_err++; $display("FAIL rnd_hdr[%0d]: got %h want %h", xfers, mem_header_o, mk_hdr(4'd1, a, 3'd6)); end
        n_cmp++; if (mem_data_o !== beat(32'h5EED0000, idx)) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", xfers, mem_data_o, beat(32'h5EED0000, idx)); end
        if (mem_last_o) lasts++;
        xfers++;
      end
      stalled = mem_v_o && !mem_ready_i;
      prev_h = mem_header_o;
      prev_d = mem_data_o;
      @(negedge clk);
    end
    mem_ready_i = 1'b1;
    n_cmp++; if (xfers !== 8) begin n_err++; $display("FAIL rnd_xfers: got %0d want 8", xfers); end
    n_cmp++; if (lasts !== 1) begin n_err++; $display("FAIL rnd_lasts: got %0d want 1", lasts); end
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL rnd_done_v: got %b want 0", mem_v_o); end
  endtask

  task automatic test_reset_mid_burst();
    mem_ready_i = 1'b1;
    send({mk_hdr(4'd1, 40'h1000, 3'd6), mk_data(32'h77770000)});
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_header_o !== mk_hdr(4'd1, 40'h1018, 3'd6)) begin n_err++; $display("FAIL mid_hdr: got %h want %h", mem_header_o, mk_hdr(4'd1, 40'h1018, 3'd6)); end
    reset_i = 1'b1;
    #1;
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_v: got %b want 0", mem_v_o); end
    n_cmp++; if (mem_ready_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_ready: got %b want 0", mem_ready_o); end
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL post_mid_v: got %b want 0", mem_v_o); end
    @(negedge clk);
    n_cmp++; if (mem_v_o !== 1'b0) begin n_err++; $display("FAIL post_mid_v2: got %b want 0", mem_v_o); end
    run_burst("after_rst", 4'd1, 40'h3000, 0, 3'd3, 1, 32'h88880000);
  endtask

  initial begin
    test_reset();
    test_aligned_write();
    test_wrap_write();
    test_small_write();
    test_read();
    test_back_to_back();
    test_random_stall();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
